// File: rtl/hilo_regfile_pkg.sv
// -----------------------------------------------------------------------------
// hilo_regfile_pkg
// Shared CPU definitions for the HI/LO register file and the ID-stage HILO
// forwarding logic: write-mode encodings, divider FSM states, iteration count
// and a small two's-complement helper.
// -----------------------------------------------------------------------------
package hilo_regfile_pkg;

    // WB-stage HI/LO write mode (hilo_mode_wb)
    typedef enum logic [1:0] {
        HILO_NONE = 2'b00,  // no write
        HILO_LO   = 2'b01,  // LO <= rdata1_wb
        HILO_HI   = 2'b10,  // HI <= rdata1_wb
        HILO_BOTH = 2'b11   // {HI,LO} <= {alu_r2_wb, alu_r1_wb}
    } hilo_mode_e;

    // Iterative divider state
    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_e;

    localparam int unsigned DIV_ITERS     = 32;
    localparam logic [4:0]  DIV_LAST_ITER = 5'(DIV_ITERS - 1);

    // Conditionally negate a 32-bit two's-complement value.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_regfile_div.sv
// -----------------------------------------------------------------------------
// div_iter
// Restoring radix-2 divider, one quotient bit per cycle, 32 cycles per divide.
// Signed divides run on magnitudes and are sign-corrected at the end.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start              launch a divide (accepted only when idle)
//   is_signed          1 = DIV, 0 = DIVU (sampled with start)
//   a, b               dividend / divisor (sampled with start)
//   cancel             abort an in-flight divide; beats start when idle
//   busy               divide in progress (registered state)
//   done               high during the final iteration cycle; the result is
//                      written by the parent on the edge that ends it
//   quotient/remainder final, sign-corrected result, valid while done=1
// -----------------------------------------------------------------------------
module div_iter
    import hilo_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q,     state_d;
    logic [4:0]  count_q,     count_d;
    logic [31:0] quot_q,      quot_d;      // dividend shifts out, quotient shifts in
    logic [31:0] rem_q,       rem_d;       // partial remainder (always < divisor)
    logic [31:0] dvsr_q,      dvsr_d;      // divisor magnitude
    logic        neg_quot_q,  neg_quot_d;
    logic        neg_rem_q,   neg_rem_d;
    logic        div_zero_q,  div_zero_d;

    logic [32:0] shifted;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] rem_step;
    logic [31:0] quot_step;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        // One iteration: shift in the next dividend bit, trial-subtract the
        // divisor. Because rem_q < divisor, bit 32 of the 33-bit difference is
        // set exactly when the subtraction would go negative.
        shifted   = {rem_q, quot_q[31]};
        trial     = shifted - {1'b0, dvsr_q};
        q_bit     = ~trial[32];
        rem_step  = q_bit ? trial[31:0] : shifted[31:0];
        quot_step = {quot_q[30:0], q_bit};

        state_d    = state_q;
        count_d    = count_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        done       = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (start && !cancel) begin
                    state_d    = DIV_RUN;
                    count_d    = 5'd0;
                    rem_d      = 32'd0;
                    quot_d     = neg_if(a, is_signed & a[31]);
                    dvsr_d     = neg_if(b, is_signed & b[31]);
                    neg_quot_d = is_signed & (a[31] ^ b[31]);
                    neg_rem_d  = is_signed & a[31];
                    div_zero_d = (b == 32'd0);
                end
            end
            DIV_RUN: begin
                if (cancel) begin
                    state_d = DIV_IDLE;
                    count_d = 5'd0;
                end else begin
                    rem_d   = rem_step;
                    quot_d  = quot_step;
                    count_d = count_q + 5'd1;
                    if (count_q == DIV_LAST_ITER) begin
                        state_d = DIV_IDLE;
                        count_d = 5'd0;
                        done    = 1'b1;
                    end
                end
            end
        endcase

        // Divide-by-zero yields an all-ones quotient whatever the signedness.
        // The remainder path already returns div_a in that case: the magnitude
        // passes through untouched and gets div_a's sign back.
        quotient  = div_zero_q ? 32'hFFFF_FFFF : neg_if(quot_step, neg_quot_q);
        remainder = neg_if(rem_step, neg_rem_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, whatever the statement order.
    // NOTE: all state, operand and partial registers are reset, so an
    // in-flight divide is abandoned cleanly on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            count_q    <= 5'd0;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
            dvsr_q     <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy = (state_q == DIV_RUN);

endmodule

// File: rtl/hilo_regfile.sv
// -----------------------------------------------------------------------------
// hilo_regfile
// Architectural HI/LO register pair with WB-stage writes and an attached
// 32-cycle iterative divider that writes its result into HI/LO.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   hilo_mode_wb     WB write mode (see hilo_mode_e)
//   rdata1_wb        data for single-half writes
//   alu_r1_wb        LO data for a both-halves write
//   alu_r2_wb        HI data for a both-halves write
//   div_start        launch a divide (ignored while busy)
//   div_signed       1 = DIV, 0 = DIVU
//   div_a, div_b     dividend, divisor
//   div_cancel       exception flush; aborts an in-flight divide
//   div_busy         divide in progress; the pipeline stalls on it
//   div_done         one-cycle pulse after the divide result is written
//   hilo             registered {HI,LO}, feeds ID-stage forwarding
// -----------------------------------------------------------------------------
module hilo_regfile
    import hilo_regfile_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  hilo_mode_wb,
    input  logic [31:0] rdata1_wb,
    input  logic [31:0] alu_r1_wb,
    input  logic [31:0] alu_r2_wb,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_a,
    input  logic [31:0] div_b,
    input  logic        div_cancel,
    output logic        div_busy,
    output logic        div_done,
    output logic [63:0] hilo
);

    logic [63:0] hilo_q,     hilo_d;
    logic        div_done_q, div_done_d;

    logic        div_wr;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    div_iter u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .is_signed (div_signed),
        .a         (div_a),
        .b         (div_b),
        .cancel    (div_cancel),
        .busy      (div_busy),
        .done      (div_wr),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    always_comb begin
        hilo_d = hilo_q;
        case (hilo_mode_e'(hilo_mode_wb))
            HILO_LO:   hilo_d[31:0]  = rdata1_wb;
            HILO_HI:   hilo_d[63:32] = rdata1_wb;
            HILO_BOTH: hilo_d        = {alu_r2_wb, alu_r1_wb};
            default:   ;
        endcase
        // A completing divide overrides any same-edge WB write, both halves.
        if (div_wr) begin
            hilo_d = {div_rem, div_quot};
        end
        div_done_d = div_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hilo_q     <= 64'd0;
            div_done_q <= 1'b0;
        end else begin
            hilo_q     <= hilo_d;
            div_done_q <= div_done_d;
        end
    end

    assign hilo     = hilo_q;
    assign div_done = div_done_q;

endmodule

// File: doc/hilo_regfile.md
HILO_REGFILE -- requirements
Module: hilo_regfile

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port hilo_mode_wb, input, 2 bits: WB write mode. 00 none; 01 LO<=rdata1_wb; 10 HI<=rdata1_wb; 11 {HI,LO}<={alu_r2_wb,alu_r1_wb}.
REQ-004 SHALL have ports rdata1_wb, alu_r1_wb and alu_r2_wb, each input, 32 bits: WB-stage write data.
REQ-005 SHALL have port div_start, input, 1 bit: launch divide; sampled only in IDLE.
REQ-006 SHALL have port div_signed, input, 1 bit: 1 for DIV, 0 for DIVU; sampled with div_start.
REQ-007 SHALL have ports div_a (dividend) and div_b (divisor), each input, 32 bits; sampled with div_start.
REQ-008 SHALL have port div_cancel, input, 1 bit: exception flush; aborts an in-flight divide.
REQ-009 SHALL have port div_busy, output, 1 bit: divide in progress; the pipeline stalls on it.
REQ-010 SHALL have port div_done, output, 1 bit: one-cycle pulse when the divide result is written.
REQ-011 SHALL have port hilo, output, 64 bits: registered {HI,LO}; this is the value the ID-stage HILO forwarding consumes.

Function
REQ-012 SHALL update hilo at the rising edge after a nonzero hilo_mode_wb; an unwritten half SHALL hold its value.
REQ-013 SHALL implement FSM states IDLE and RUN. IDLE->RUN on div_start. RUN->IDLE after 32 iterations or on div_cancel.
REQ-014 SHALL, on the edge sampling div_start in IDLE, latch operands, compute magnitudes when div_signed=1, clear the partial remainder and load iteration counter 0.
REQ-015 SHALL perform one restoring radix-2 iteration per RUN cycle (shift, 33-bit trial subtract, quotient bit); div_busy=1 for exactly 32 cycles.
REQ-016 SHALL, at the 32nd RUN edge, write HI=remainder and LO=quotient, return to IDLE, and assert div_done for the following cycle only.
REQ-017 SHALL apply sign correction for signed divides: quotient negated if operand signs differ; remainder takes the sign of div_a.
REQ-018 SHALL produce LO=0xFFFFFFFF, HI=div_a for div_b=0, regardless of div_signed, with the same 32-cycle latency.
REQ-019 SHALL produce LO=0x80000000, HI=0 for a signed 0x80000000/0xFFFFFFFF, with no trap.
REQ-020 SHALL ignore div_start while in RUN.
REQ-021 SHALL, on div_cancel in RUN, return to IDLE at the next edge with no HILO write and no div_done; div_cancel in IDLE SHALL have no effect; div_cancel SHALL take priority over div_start.
REQ-022 SHALL, when the divide write and a nonzero hilo_mode_wb land on the same edge, let the divide result win for both halves.
REQ-023 SHALL keep hilo_mode_wb writes functional during RUN; they are overwritten at completion.

Reset
REQ-024 SHALL force, on rst assertion and independent of clk: hilo=0, FSM=IDLE, counter=0, div_busy=0, div_done=0, and all operand and partial registers=0.
REQ-025 SHALL abandon an in-flight divide on rst assertion mid-operation; no result SHALL be written after release.
REQ-026 SHALL accept div_start on the first rising edge after rst deasserts.

Structure
REQ-027 SHALL place the HILO_MODE encodings (NONE/LO/HI/BOTH) and the FSM state encoding in the shared CPU package, reused by the ID-stage forwarding logic.
REQ-028 SHALL implement the iterative divider as one sub-module, div_iter (operands, start, cancel in; quotient, remainder, done out), instantiated in hilo_regfile.

Verification
REQ-029 SHALL cover: reset; then mode 11, alu_r2_wb=0x12345678, alu_r1_wb=0x9ABCDEF0 -> next cycle hilo=0x123456789ABCDEF0.
REQ-030 SHALL cover: mode 01, rdata1_wb=0xDEADBEEF, then mode 10, rdata1_wb=0xCAFEF00D -> hilo=0xCAFEF00DDEADBEEF.
REQ-031 SHALL cover: DIVU 100/7 -> div_busy high 32 cycles, then div_done pulse, with HI=0x00000002, LO=0x0000000E.
REQ-032 SHALL cover: DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; and DIVU 5/0 -> LO=0xFFFFFFFF, HI=0x00000005.
REQ-033 SHALL cover: div_cancel at RUN cycle 10 -> div_busy=0 next cycle, no div_done, hilo unchanged; repeat with rst at cycle 10 -> hilo=0.
REQ-034 SHALL cover: mode 11 on the completion edge of DIVU 9/4 -> hilo=0x0000000100000002.
